// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI flash pad arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      TURN   = 2'd3
   } arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_DBG = 1;

endpackage

// File: rtl/spi_arb_hold_timer.sv
// Saturating up-counter with synchronous clear. The sat output flags that the
// count will equal MAX after the coming edge, so a registered consumer lines up
// with the counter itself.
module spi_arb_hold_timer #(
   parameter int W   = 11,
   parameter int MAX = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic sat
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_next;

   // Next count: clear wins, otherwise count up and stick at MAX.
   always_comb begin
      cnt_next = cnt;
      if (clr)
         cnt_next = '0;
      else if (en && (cnt != MAX_C))
         cnt_next = cnt + W'(1);
   end

   assign sat = (cnt_next == MAX_C);

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else
         cnt <= cnt_next;
   end

endmodule

// File: rtl/spi_flash_pad_arbiter.sv
// Shares one SPI flash pad set between the CPU flash controller (port 0) and
// the JTAG debug flash bridge (port 1). Ownership only changes while the owner
// has CS_n high, followed by a pad-idle turnaround gap.
module spi_flash_pad_arbiter
   import spi_arb_pkg::*;
#(
   parameter int DATA_W      = 1,
   parameter int TURN_CYCLES = 2,
   parameter int MAX_HOLD    = 1024,
   parameter int HOLD_W      = 11
) (
   input  logic                ext_clk,
   input  logic                ext_rst,
   input  logic [1:0]          req,
   output logic [1:0]          gnt,
   output logic [1:0]          yield,
   input  logic                dbg_lock,
   input  logic [1:0]          rq_cs_n,
   input  logic [1:0]          rq_clk,
   input  logic [2*DATA_W-1:0] rq_sdat_o,
   input  logic [2*DATA_W-1:0] rq_sdat_oe,
   output logic [2*DATA_W-1:0] rq_sdat_i,
   output logic                pad_cs_n,
   output logic                pad_clk,
   output logic [DATA_W-1:0]   pad_sdat_o,
   output logic [DATA_W-1:0]   pad_sdat_oe,
   input  logic [DATA_W-1:0]   pad_sdat_i,
   output logic                err_proto
);

   localparam int TURN_W = $clog2(TURN_CYCLES + 1);

   arb_state_t state;
   logic       rr_ptr;
   logic [1:0] eligible;
   logic       in_grant;
   logic       hold_sat;
   logic       turn_sat;
   logic       yield_cond_cpu;
   logic       yield_cond_dbg;

   assign eligible = req & (dbg_lock ? 2'b10 : 2'b11);
   assign in_grant = (state == GRANT0) || (state == GRANT1);

   // Port 0 is asked to yield when it has held long enough with port 1 waiting,
   // or straight away when the debugger locks the pads.
   assign yield_cond_cpu = (hold_sat && req[PORT_DBG]) || dbg_lock;
   assign yield_cond_dbg = hold_sat && eligible[PORT_CPU];

   spi_arb_hold_timer #(
      .W   (HOLD_W),
      .MAX (MAX_HOLD)
   ) u_hold_timer (
      .clk   (ext_clk),
      .rst_n (ext_rst),
      .clr   (!in_grant),
      .en    (in_grant),
      .sat   (hold_sat)
   );

   spi_arb_hold_timer #(
      .W   (TURN_W),
      .MAX (TURN_CYCLES)
   ) u_turn_timer (
      .clk   (ext_clk),
      .rst_n (ext_rst),
      .clr   (state != TURN),
      .en    (state == TURN),
      .sat   (turn_sat)
   );

   // Arbitration FSM with registered grant, yield hint and sticky protocol error.
   always_ff @(posedge ext_clk) begin
      if (!ext_rst) begin
         state     <= IDLE;
         gnt       <= 2'b00;
         yield     <= 2'b00;
         err_proto <= 1'b0;
         rr_ptr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((eligible == 2'b11 && !rr_ptr) || eligible == 2'b01) begin
                  state <= GRANT0;
                  gnt   <= 2'b01;
               end else if (eligible != 2'b00) begin
                  state <= GRANT1;
                  gnt   <= 2'b10;
               end
            end
            GRANT0: begin
               if (!req[PORT_CPU] && rq_cs_n[PORT_CPU]) begin
                  state  <= TURN;
                  gnt    <= 2'b00;
                  yield  <= 2'b00;
                  rr_ptr <= 1'b1;
               end else begin
                  if (!req[PORT_CPU])
                     err_proto <= 1'b1;
                  if (yield_cond_cpu)
                     yield[PORT_CPU] <= 1'b1;
               end
            end
            GRANT1: begin
               if (!req[PORT_DBG] && rq_cs_n[PORT_DBG]) begin
                  state  <= TURN;
                  gnt    <= 2'b00;
                  yield  <= 2'b00;
                  rr_ptr <= 1'b0;
               end else begin
                  if (!req[PORT_DBG])
                     err_proto <= 1'b1;
                  if (yield_cond_dbg)
                     yield[PORT_DBG] <= 1'b1;
               end
            end
            TURN: begin
               if (turn_sat)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pad and return-data mux driven from the registered state; idle pads otherwise.
   always_comb begin
      pad_cs_n    = 1'b1;
      pad_clk     = 1'b0;
      pad_sdat_o  = '0;
      pad_sdat_oe = '0;
      rq_sdat_i   = '0;
      case (state)
         GRANT0: begin
            pad_cs_n    = rq_cs_n[PORT_CPU];
            pad_clk     = rq_clk[PORT_CPU];
            pad_sdat_o  = rq_sdat_o[PORT_CPU*DATA_W +: DATA_W];
            pad_sdat_oe = rq_sdat_oe[PORT_CPU*DATA_W +: DATA_W];
            rq_sdat_i[PORT_CPU*DATA_W +: DATA_W] = pad_sdat_i;
         end
         GRANT1: begin
            pad_cs_n    = rq_cs_n[PORT_DBG];
            pad_clk     = rq_clk[PORT_DBG];
            pad_sdat_o  = rq_sdat_o[PORT_DBG*DATA_W +: DATA_W];
            pad_sdat_oe = rq_sdat_oe[PORT_DBG*DATA_W +: DATA_W];
            rq_sdat_i[PORT_DBG*DATA_W +: DATA_W] = pad_sdat_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_flash_pad_arbiter.sv
// Directed self-checking bench for the SPI flash pad arbiter (default parameters).
module tb_spi_flash_pad_arbiter;

   logic       ext_clk;
   logic       ext_rst;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] yield;
   logic       dbg_lock;
   logic [1:0] rq_cs_n;
   logic [1:0] rq_clk;
   logic [1:0] rq_sdat_o;
   logic [1:0] rq_sdat_oe;
   logic [1:0] rq_sdat_i;
   logic       pad_cs_n;
   logic       pad_clk;
   logic [0:0] pad_sdat_o;
   logic [0:0] pad_sdat_oe;
   logic [0:0] pad_sdat_i;
   logic       err_proto;

   int check_count = 0;
   int pass_count  = 0;

   spi_flash_pad_arbiter dut (
      .ext_clk     (ext_clk),
      .ext_rst     (ext_rst),
      .req         (req),
      .gnt         (gnt),
      .yield       (yield),
      .dbg_lock    (dbg_lock),
      .rq_cs_n     (rq_cs_n),
      .rq_clk      (rq_clk),
      .rq_sdat_o   (rq_sdat_o),
      .rq_sdat_oe  (rq_sdat_oe),
      .rq_sdat_i   (rq_sdat_i),
      .pad_cs_n    (pad_cs_n),
      .pad_clk     (pad_clk),
      .pad_sdat_o  (pad_sdat_o),
      .pad_sdat_oe (pad_sdat_oe),
      .pad_sdat_i  (pad_sdat_i),
      .err_proto   (err_proto)
   );

   // Free-running 100 MHz clock.
   initial ext_clk = 1'b0;
   always #5 ext_clk = ~ext_clk;

   task automatic applyStimulus(input logic [1:0] r, input logic lock, input logic [1:0] cs);
      req      = r;
      dbg_lock = lock;
      rq_cs_n  = cs;
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge ext_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      if (obs === exp)
         pass_count++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Directed scenarios, each with hand-computed expectations.
   initial begin
      ext_rst    = 1'b0;
      req        = 2'b00;
      dbg_lock   = 1'b0;
      rq_cs_n    = 2'b11;
      rq_clk     = 2'b00;
      rq_sdat_o  = 2'b00;
      rq_sdat_oe = 2'b00;
      pad_sdat_i = 1'b0;
      step(2);

      // Reset state
      checkOutput("rst_gnt", 32'(gnt), 32'h0);
      checkOutput("rst_yield", 32'(yield), 32'h0);
      checkOutput("rst_err", 32'(err_proto), 32'h0);
      checkOutput("rst_pad_cs_n", 32'(pad_cs_n), 32'h1);
      checkOutput("rst_pad_oe", 32'(pad_sdat_oe), 32'h0);
      ext_rst = 1'b1;

      // Single request from port 0
      applyStimulus(2'b01, 1'b0, 2'b11);
      checkOutput("t1_gnt_before", 32'(gnt), 32'h0);
      step(1);
      checkOutput("t1_gnt", 32'(gnt), 32'h1);
      rq_clk     = 2'b01;
      rq_sdat_o  = 2'b01;
      rq_sdat_oe = 2'b01;
      pad_sdat_i = 1'b1;
      applyStimulus(2'b01, 1'b0, 2'b10);
      checkOutput("t1_pad_cs_n", 32'(pad_cs_n), 32'h0);
      checkOutput("t1_pad_clk", 32'(pad_clk), 32'h1);
      checkOutput("t1_pad_sdat_o", 32'(pad_sdat_o), 32'h1);
      checkOutput("t1_pad_oe", 32'(pad_sdat_oe), 32'h1);
      checkOutput("t1_rq_sdat_i", 32'(rq_sdat_i), 32'h1);
      rq_clk = 2'b10;
      applyStimulus(2'b01, 1'b0, 2'b00);
      checkOutput("t1_nonowner_clk", 32'(pad_clk), 32'h0);
      rq_clk     = 2'b00;
      rq_sdat_o  = 2'b00;
      rq_sdat_oe = 2'b00;
      pad_sdat_i = 1'b0;
      applyStimulus(2'b00, 1'b0, 2'b11);
      step(1);
      checkOutput("t1_release", 32'(gnt), 32'h0);
      checkOutput("t1_err", 32'(err_proto), 32'h0);
      step(3);

      // Both request from reset: port 0 first, port 1 after a 3-cycle gap
      ext_rst = 1'b0;
      applyStimulus(2'b00, 1'b0, 2'b11);
      step(1);
      ext_rst = 1'b1;
      applyStimulus(2'b11, 1'b0, 2'b11);
      step(1);
      checkOutput("t2_gnt0", 32'(gnt), 32'h1);
      step(3);
      checkOutput("t2_gnt0_held", 32'(gnt), 32'h1);
      applyStimulus(2'b10, 1'b0, 2'b11);
      step(1);
      checkOutput("t2_fall", 32'(gnt), 32'h0);
      applyStimulus(2'b10, 1'b0, 2'b00);
      checkOutput("t2_turn_pad_cs_n", 32'(pad_cs_n), 32'h1);
      step(1);
      checkOutput("t2_gap1", 32'(gnt), 32'h0);
      step(1);
      checkOutput("t2_gap2", 32'(gnt), 32'h0);
      step(1);
      checkOutput("t2_gnt1", 32'(gnt), 32'h2);
      checkOutput("t2_pad_cs_n", 32'(pad_cs_n), 32'h0);
      applyStimulus(2'b00, 1'b0, 2'b11);
      step(1);
      checkOutput("t2_rel1", 32'(gnt), 32'h0);
      step(3);

      // Debug lock: only port 1 may be granted; yield on lock during port 0 grant
      applyStimulus(2'b11, 1'b1, 2'b11);
      step(1);
      checkOutput("t5_lock_gnt", 32'(gnt), 32'h2);
      applyStimulus(2'b01, 1'b1, 2'b11);
      step(1);
      checkOutput("t5_rel", 32'(gnt), 32'h0);
      step(4);
      checkOutput("t5_locked_out", 32'(gnt), 32'h0);
      applyStimulus(2'b01, 1'b0, 2'b11);
      step(1);
      checkOutput("t5_unlock_gnt", 32'(gnt), 32'h1);
      checkOutput("t5_yield_pre", 32'(yield), 32'h0);
      applyStimulus(2'b01, 1'b1, 2'b11);
      step(1);
      checkOutput("t5_lock_yield", 32'(yield), 32'h1);
      step(2);
      checkOutput("t5_grant_kept", 32'(gnt), 32'h1);
      applyStimulus(2'b00, 1'b1, 2'b11);
      step(1);
      checkOutput("t5_rel_gnt", 32'(gnt), 32'h0);
      checkOutput("t5_rel_yield", 32'(yield), 32'h0);
      applyStimulus(2'b00, 1'b0, 2'b11);
      step(3);

      // Owner drops req with cs_n low: sticky error, grant held until cs_n rises
      applyStimulus(2'b01, 1'b0, 2'b11);
      step(1);
      checkOutput("t4_gnt", 32'(gnt), 32'h1);
      applyStimulus(2'b00, 1'b0, 2'b10);
      step(1);
      checkOutput("t4_err", 32'(err_proto), 32'h1);
      checkOutput("t4_held", 32'(gnt), 32'h1);
      step(2);
      checkOutput("t4_held2", 32'(gnt), 32'h1);
      applyStimulus(2'b00, 1'b0, 2'b11);
      step(1);
      checkOutput("t4_rel", 32'(gnt), 32'h0);
      checkOutput("t4_err_sticky", 32'(err_proto), 32'h1);
      step(3);

      // Reset during a port 1 transaction
      applyStimulus(2'b10, 1'b0, 2'b11);
      step(1);
      checkOutput("t6_gnt1", 32'(gnt), 32'h2);
      rq_sdat_oe = 2'b10;
      applyStimulus(2'b10, 1'b0, 2'b01);
      checkOutput("t6_pad_cs_n_low", 32'(pad_cs_n), 32'h0);
      checkOutput("t6_pad_oe_on", 32'(pad_sdat_oe), 32'h1);
      ext_rst = 1'b0;
      step(1);
      checkOutput("t6_gnt", 32'(gnt), 32'h0);
      checkOutput("t6_pad_cs_n", 32'(pad_cs_n), 32'h1);
      checkOutput("t6_pad_oe", 32'(pad_sdat_oe), 32'h0);
      checkOutput("t6_err_clr", 32'(err_proto), 32'h0);
      ext_rst    = 1'b1;
      rq_sdat_oe = 2'b00;
      applyStimulus(2'b00, 1'b0, 2'b11);
      step(1);

      // Long hold with port 1 waiting: yield at count 1024, no forced switch
      applyStimulus(2'b11, 1'b0, 2'b11);
      step(1);
      checkOutput("t3_gnt0", 32'(gnt), 32'h1);
      step(1023);
      checkOutput("t3_yield_1023", 32'(yield), 32'h0);
      step(1);
      checkOutput("t3_yield_1024", 32'(yield), 32'h1);
      step(5);
      checkOutput("t3_yield_sat", 32'(yield), 32'h1);
      checkOutput("t3_no_switch", 32'(gnt), 32'h1);
      applyStimulus(2'b10, 1'b0, 2'b10);
      step(1);
      checkOutput("t3_cs_low_held", 32'(gnt), 32'h1);
      applyStimulus(2'b10, 1'b0, 2'b11);
      step(1);
      checkOutput("t3_rel", 32'(gnt), 32'h0);
      checkOutput("t3_yield_clr", 32'(yield), 32'h0);
      step(3);
      checkOutput("t3_gnt1", 32'(gnt), 32'h2);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
